// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage RV32I core: memory-wait stalls,
// EX-resolved redirects, load-use bubbles, timeout halt and perf counters.
module hazard_ctrl #(
  parameter int TIMEOUT = 255,
  parameter int TMO_W   = 8,
  parameter int CNT_W   = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [31:0]      inst_ID_i,
  input  logic [31:0]      inst_EX_i,
  input  logic             br_taken_EX_i,
  input  logic             dmem_req_MEM_i,
  input  logic             dmem_ack_i,
  output logic             pc_en_o,
  output logic             ifid_en_o,
  output logic             ifid_flush_o,
  output logic             idex_en_o,
  output logic             idex_flush_o,
  output logic             exmem_en_o,
  output logic             memwb_flush_o,
  output logic             halted_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  // state    | meaning
  // RUN      | normal flow
  // WAIT_MEM | data memory access outstanding
  // HALT     | data memory timed out, held until reset
  typedef enum logic [1:0] {RUN, WAIT_MEM, HALT} state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  state_t           state;
  logic [TMO_W-1:0] wait_cnt;

  logic [6:0] op_id, op_ex;
  logic [4:0] rd_ex, rs1_id, rs2_id;
  logic       use_rs1, use_rs2, load_use, mem_wait, redirect, halt;
  logic       unused_bits;

  assign op_id  = inst_ID_i[6:0];
  assign op_ex  = inst_EX_i[6:0];
  assign rd_ex  = inst_EX_i[11:7];
  assign rs1_id = inst_ID_i[19:15];
  assign rs2_id = inst_ID_i[24:20];
  assign unused_bits = ^{inst_ID_i[31:25], inst_ID_i[14:7], inst_EX_i[31:12]};

  assign use_rs1 = (op_id == OP_REG) || (op_id == OP_IMM) || (op_id == OP_LOAD) ||
                   (op_id == OP_STORE) || (op_id == OP_BRANCH) || (op_id == OP_JALR);
  assign use_rs2 = (op_id == OP_REG) || (op_id == OP_STORE) || (op_id == OP_BRANCH);

  assign load_use = (op_ex == OP_LOAD) && (rd_ex != 5'd0) &&
                    ((use_rs1 && (rd_ex == rs1_id)) || (use_rs2 && (rd_ex == rs2_id)));

  assign halt     = (state == HALT);
  assign mem_wait = dmem_req_MEM_i & ~dmem_ack_i;
  assign redirect = ~halt & ~mem_wait & br_taken_EX_i;
  assign halted_o = halt;

  always_comb begin
    pc_en_o       = 1'b1;
    ifid_en_o     = 1'b1;
    ifid_flush_o  = 1'b0;
    idex_en_o     = 1'b1;
    idex_flush_o  = 1'b0;
    exmem_en_o    = 1'b1;
    memwb_flush_o = 1'b0;
    if (halt) begin
      pc_en_o    = 1'b0;
      ifid_en_o  = 1'b0;
      idex_en_o  = 1'b0;
      exmem_en_o = 1'b0;
    end else if (mem_wait) begin
      // WB retires the MEM-stage result once, then receives bubbles
      pc_en_o       = 1'b0;
      ifid_en_o     = 1'b0;
      idex_en_o     = 1'b0;
      exmem_en_o    = 1'b0;
      memwb_flush_o = 1'b1;
    end else if (br_taken_EX_i) begin
      ifid_flush_o = 1'b1;
      idex_flush_o = 1'b1;
    end else if (load_use) begin
      pc_en_o      = 1'b0;
      ifid_en_o    = 1'b0;
      idex_flush_o = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= RUN;
      wait_cnt    <= '0;
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
    end else begin
      case (state)
        RUN: begin
          if (mem_wait) begin
            state    <= WAIT_MEM;
            wait_cnt <= TMO_W'(1);
          end
        end
        WAIT_MEM: begin
          if (!mem_wait) begin
            state    <= RUN;
            wait_cnt <= '0;
          end else if (wait_cnt == TMO_W'(TIMEOUT)) begin
            state <= HALT;
          end else begin
            wait_cnt <= wait_cnt + TMO_W'(1);
          end
        end
        HALT:    state <= HALT;
        default: state <= RUN;
      endcase

      if (!pc_en_o && (stall_cnt_o != {CNT_W{1'b1}}))
        stall_cnt_o <= stall_cnt_o + CNT_W'(1);
      if (redirect && (flush_cnt_o != {CNT_W{1'b1}}))
        flush_cnt_o <= flush_cnt_o + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: per-cycle comparison against a rule-level
// model plus hand-computed literal checks; a second instance covers saturation.
module tb_hazard_ctrl;
  localparam int T1 = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] inst_id, inst_ex;
  logic        br, req, ack, req2;

  logic        pc_en, ifid_en, ifid_fl, idex_en, idex_fl, exmem_en, memwb_fl, halted;
  logic [31:0] stall_cnt, flush_cnt;
  logic        d_pc, d_ifen, d_iffl, d_iden, d_idfl, d_exen, d_mwfl, d_halt;
  logic [3:0]  stall2, flush2;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.TIMEOUT(T1), .TMO_W(8), .CNT_W(32)) dut (
    .clk_i(clk), .rst_i(rst), .inst_ID_i(inst_id), .inst_EX_i(inst_ex),
    .br_taken_EX_i(br), .dmem_req_MEM_i(req), .dmem_ack_i(ack),
    .pc_en_o(pc_en), .ifid_en_o(ifid_en), .ifid_flush_o(ifid_fl),
    .idex_en_o(idex_en), .idex_flush_o(idex_fl), .exmem_en_o(exmem_en),
    .memwb_flush_o(memwb_fl), .halted_o(halted),
    .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt));

  hazard_ctrl #(.TIMEOUT(200), .TMO_W(8), .CNT_W(4)) dut_sat (
    .clk_i(clk), .rst_i(rst), .inst_ID_i(32'h13), .inst_EX_i(32'h13),
    .br_taken_EX_i(1'b0), .dmem_req_MEM_i(req2), .dmem_ack_i(1'b0),
    .pc_en_o(d_pc), .ifid_en_o(d_ifen), .ifid_flush_o(d_iffl),
    .idex_en_o(d_iden), .idex_flush_o(d_idfl), .exmem_en_o(d_exen),
    .memwb_flush_o(d_mwfl), .halted_o(d_halt),
    .stall_cnt_o(stall2), .flush_cnt_o(flush2));

  function automatic logic [31:0] enc(int op, int rd, int rs1, int rs2);
    return 32'(op + rd * 128 + rs1 * 32768 + rs2 * 1048576);
  endfunction

  localparam logic [31:0] NOP = 32'h0000_0013;
  logic [31:0] lw_x5, lw_x0, add_565, add_600, addi_rs2_5, sw_x5;

  // Rule-level model: does ID read a register the EX load is about to write?
  function automatic bit model_load_use(logic [31:0] id, logic [31:0] ex);
    int op_e, rd, op_i, r1, r2;
    bit reads1, reads2;
    op_e = int'(ex % 128); rd = int'((ex / 128) % 32);
    op_i = int'(id % 128); r1 = int'((id / 32768) % 32); r2 = int'((id / 1048576) % 32);
    reads1 = (op_i == 51) || (op_i == 19) || (op_i == 3) || (op_i == 35) ||
             (op_i == 99) || (op_i == 103);
    reads2 = (op_i == 51) || (op_i == 35) || (op_i == 99);
    return (op_e == 3) && (rd != 0) && ((reads1 && rd == r1) || (reads2 && rd == r2));
  endfunction

  bit     m_halt;
  int     m_run;
  longint m_stall, m_flush;

  // {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_flush}
  function automatic logic [6:0] model_out();
    if (m_halt)                          return 7'b0000000;
    if (req && !ack)                     return 7'b0000001;
    if (br)                              return 7'b1111110;
    if (model_load_use(inst_id, inst_ex)) return 7'b0001110;
    return 7'b1101010;
  endfunction

  always @(posedge clk or posedge rst) begin
    logic [6:0] e;
    if (rst) begin
      m_halt = 0; m_run = 0; m_stall = 0; m_flush = 0;
    end else begin
      e = model_out();
      if (!e[6]) m_stall = m_stall + 1;
      if (!m_halt && !(req && !ack) && br) m_flush = m_flush + 1;
      if (!m_halt) begin
        if (req && !ack) begin
          m_run = m_run + 1;
          if (m_run == T1 + 1) m_halt = 1;
        end else m_run = 0;
      end
    end
  end

  task automatic chk(string name, longint act, longint exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("outputs", longint'({pc_en, ifid_en, ifid_fl, idex_en, idex_fl, exmem_en, memwb_fl}),
        longint'(model_out()));
    chk("halted", longint'(halted), longint'(m_halt));
    chk("stall_cnt", longint'(stall_cnt), (m_stall > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_stall);
    chk("flush_cnt", longint'(flush_cnt), m_flush);
  end

  task automatic set(logic [31:0] id, logic [31:0] ex, logic b, logic r, logic a);
    inst_id = id; inst_ex = ex; br = b; req = r; ack = a;
  endtask

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    lw_x5      = enc(3, 5, 1, 0) + 32'h2000;
    lw_x0      = enc(3, 0, 1, 0) + 32'h2000;
    add_565    = enc(51, 6, 5, 2);
    add_600    = enc(51, 6, 0, 0);
    addi_rs2_5 = enc(19, 6, 0, 5);
    sw_x5      = enc(35, 0, 1, 5) + 32'h2000;
    req2 = 0;
    set(NOP, NOP, 0, 0, 0);
    rst = 1'b1;
    tick(2);
    chk("rst_pc_en", pc_en, 1); chk("rst_memwb_flush", memwb_fl, 0);
    chk("rst_stall", stall_cnt, 0); chk("rst_halted", halted, 0);
    rst = 1'b0;
    tick(1);

    set(add_565, lw_x5, 0, 0, 0); #1;
    chk("lu_pc_en", pc_en, 0); chk("lu_ifid_en", ifid_en, 0);
    chk("lu_idex_flush", idex_fl, 1); chk("lu_idex_en", idex_en, 1);
    tick(1);
    set(add_565, NOP, 0, 0, 0); #1;
    chk("lu_release", pc_en, 1); chk("lu_stall", stall_cnt, 1);
    tick(1);
    set(addi_rs2_5, lw_x5, 0, 0, 0); #1; chk("opimm_rs2", pc_en, 1); tick(1);
    set(add_600, lw_x0, 0, 0, 0); #1; chk("lw_x0", pc_en, 1); tick(1);
    chk("no_extra_stall", stall_cnt, 1);
    set(sw_x5, lw_x5, 0, 0, 0); #1; chk("store_rs2", pc_en, 0); tick(1);
    set(NOP, NOP, 0, 0, 0); chk("store_stall", stall_cnt, 2);

    set(NOP, NOP, 1, 0, 0); #1;
    chk("br_ifid_flush", ifid_fl, 1); chk("br_idex_flush", idex_fl, 1); chk("br_pc_en", pc_en, 1);
    tick(1); set(NOP, NOP, 0, 0, 0); chk("br_flush_cnt", flush_cnt, 1);
    set(add_565, lw_x5, 1, 0, 0); #1;
    chk("br_lu_pc_en", pc_en, 1); chk("br_lu_idex_flush", idex_fl, 1);
    tick(1); set(NOP, NOP, 0, 0, 0);
    chk("br_lu_flush_cnt", flush_cnt, 2); chk("br_lu_stall", stall_cnt, 2);

    set(NOP, NOP, 0, 1, 0); #1;
    chk("mw_exmem_en", exmem_en, 0); chk("mw_memwb_flush", memwb_fl, 1);
    tick(3);
    set(NOP, NOP, 0, 1, 1); #1;
    chk("mw_ack_pc_en", pc_en, 1); chk("mw_ack_memwb", memwb_fl, 0);
    tick(1); set(NOP, NOP, 0, 0, 0); chk("mw_stall", stall_cnt, 5);

    set(NOP, NOP, 1, 1, 0); #1; chk("mwbr_no_flush", ifid_fl, 0);
    tick(2);
    set(NOP, NOP, 1, 1, 1); #1;
    chk("mwbr_ifid_flush", ifid_fl, 1); chk("mwbr_idex_flush", idex_fl, 1);
    tick(1); set(NOP, NOP, 0, 0, 0);
    chk("mwbr_flush_cnt", flush_cnt, 3); chk("mwbr_stall", stall_cnt, 7);

    set(NOP, NOP, 0, 1, 1); #1; chk("zero_wait", pc_en, 1); tick(1);
    chk("zero_wait_stall", stall_cnt, 7);

    set(NOP, NOP, 0, 1, 0);
    tick(4); chk("tmo_not_yet", halted, 0);
    tick(1); chk("tmo_halted", halted, 1); chk("tmo_stall", stall_cnt, 12);
    set(NOP, NOP, 1, 1, 1); #1; chk("halt_pc_en", pc_en, 0); chk("halt_flush", ifid_fl, 0);
    tick(3); chk("halt_sticky", halted, 1); chk("halt_stall", stall_cnt, 15);

    @(posedge clk); #3;
    rst = 1'b1; set(NOP, NOP, 0, 0, 0); #1;
    chk("arst_halted", halted, 0); chk("arst_stall", stall_cnt, 0);
    chk("arst_flush", flush_cnt, 0); chk("arst_pc_en", pc_en, 1);
    tick(1); rst = 1'b0;
    set(add_565, lw_x5, 0, 0, 0); #1; chk("post_rst_lu", pc_en, 0);
    tick(1); set(NOP, NOP, 0, 0, 0); chk("post_rst_stall", stall_cnt, 1);

    req2 = 1'b1;
    tick(10); chk("sat_mid", stall2, 10);
    tick(10); chk("sat_top", stall2, 15);
    tick(3);  chk("sat_hold", stall2, 15);
    req2 = 1'b0;
    tick(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline control unit for the 5-stage RV32I core (IF/ID/EX/MEM/WB).
- Sequences stage enables and flushes for three cases: data-memory wait states, taken branch/jump redirects resolved in EX, and load-use hazards that MEM/WB forwarding cannot cover.
- Also keeps saturating stall and flush performance counters.
- Enters a halt state when a data-memory access times out.

Parameters:
- TIMEOUT, 255: maximum number of consecutive WAIT_MEM cycles without dmem_ack_i before halting.
- TMO_W, 8: width of the wait counter; must satisfy TIMEOUT < 2^TMO_W.
- CNT_W, 32: width of the performance counters.

Ports:
- clk_i  in  1  core clock.
- rst_i  in  1  reset; asynchronous, active-high.
- inst_ID_i  in  32  instruction in the ID stage.
- inst_EX_i  in  32  instruction in the EX stage.
- br_taken_EX_i  in  1  the EX instruction redirects the PC (taken branch, JAL, JALR).
- dmem_req_MEM_i  in  1  the MEM instruction is a load or store.
- dmem_ack_i  in  1  data memory completes the access this cycle.
- pc_en_o  out  1  PC register update enable.
- ifid_en_o  out  1  IF/ID register enable.
- ifid_flush_o  out  1  load a NOP into IF/ID.
- idex_en_o  out  1  ID/EX register enable.
- idex_flush_o  out  1  load a NOP into ID/EX.
- exmem_en_o  out  1  EX/MEM register enable.
- memwb_flush_o  out  1  load a NOP into MEM/WB.
- halted_o  out  1  sticky halt; set on timeout.
- stall_cnt_o  out  CNT_W  count of cycles in which pc_en_o=0.
- flush_cnt_o  out  CNT_W  count of redirect flush events.

Behaviour:
- Reset values (asynchronous, rst_i=1):
  - State RUN; wait counter 0; both performance counters 0; halted_o=0.
  - Outputs follow the RUN/idle combinational values: all *_en_o=1, all *_flush_o=0.
- States:
  - RUN: normal flow.
  - WAIT_MEM: waiting on data memory.
  - HALT: halted after timeout.
- Outputs are Mealy (combinational on state plus inputs). Priority order: HALT > mem wait > redirect > load-use.
- mem_wait = dmem_req_MEM_i & ~dmem_ack_i. This is evaluated in RUN and WAIT_MEM alike.
- mem_wait=1:
  - pc_en, ifid_en, idex_en, exmem_en all 0; memwb_flush=1, so WB retires once and then sees bubbles.
  - ifid_flush=0, idex_flush=0.
  - A pending br_taken_EX_i is not acted on; it is still asserted when EX is released.
- Redirect (no mem_wait, br_taken_EX_i=1):
  - All enables 1; ifid_flush=1 and idex_flush=1.
  - flush_cnt increments by 1.
  - Load-use detection is ignored that cycle.
- Load-use condition:
  - inst_EX is a LOAD (opcode 0000011) with rd_EX != 0.
  - AND either rd_EX == rs1_ID with ID opcode in {OP, OP-IMM, LOAD, STORE, BRANCH, JALR}, or rd_EX == rs2_ID with ID opcode in {OP, STORE, BRANCH}.
- Load-use response (no mem_wait, no redirect):
  - pc_en=0, ifid_en=0; idex_flush=1, idex_en=1; exmem_en=1.
  - Exactly one bubble per hazard; the stall releases the next cycle once the load has moved to MEM.
- Transitions:
  - RUN → WAIT_MEM on mem_wait; the wait counter loads 1.
  - WAIT_MEM on dmem_ack_i → RUN. That cycle is a normal advance: the pipeline moves and the redirect/load-use rules apply. The wait counter clears.
  - WAIT_MEM without ack: the counter increments. When the counter equals TIMEOUT and there is no ack → HALT.
  - HALT: halted_o=1; all enables 0, all flushes 0. Left only by rst_i.
- A zero-wait access (req and ack in the same cycle) causes no stall and stays in RUN.
- Counters:
  - stall_cnt increments in every cycle with pc_en_o=0, including HALT cycles.
  - Both counters saturate at all-ones and do not wrap.
- Reset asserted mid-WAIT_MEM or in HALT returns immediately to RUN with counters cleared.

Test Plan:
- Load-use: EX=lw x5,0(x1); ID=add x6,x5,x2.
  - Required: one cycle with pc_en=0, ifid_en=0, idex_flush=1; the next cycle all enables 1; stall_cnt=1.
  - Repeat with ID=addi x6,x0,1 using rs2 field=5 (rs2 not used by OP-IMM): no stall.
  - Repeat with lw x0: no stall.
- Redirect: br_taken_EX_i=1 for one cycle.
  - Required: ifid_flush=idex_flush=1, pc_en=1; flush_cnt 0→1.
  - Redirect coinciding with a load-use match: flush only, no stall.
- Memory wait: req=1, ack=0 for 3 cycles, then ack=1.
  - Required: 3 cycles with all enables 0 and memwb_flush=1; state returns to RUN on the ack cycle with enables 1; stall_cnt=3.
- Wait plus redirect: br_taken_EX_i held high during a 2-cycle wait.
  - Required: no flush during the wait; ifid/idex flush on the ack cycle; flush_cnt=1.
- Timeout (TIMEOUT=4): req=1, ack never.
  - Required: HALT is entered after 4 wait cycles, halted_o=1 and stays 1.
  - Then assert rst_i asynchronously mid-cycle: halted_o=0, counters 0, state RUN.
- Saturation (CNT_W=4): hold a memory wait for 20 cycles with a large TIMEOUT.
  - Required: stall_cnt stops at 15.
